spi_peripheral: RTL

Oversampling SPI target front end that sits directly upstream of the camera SPI register block. It samples the host's SPI pins in the system clock domain and decodes each chip-select framed transaction into an op-code, a stream of operand bytes with a running operand count, and a serial response stream. The response stream is built from the byte that the register block presents. It owns all pin-level timing, so downstream register logic sees only single-clock-domain strobes.

---
 rtl/spi_peripheral.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// Oversampling SPI target front end (mode 0, MSB first).
// Synchronizes the host pins into clock_in, frames transactions on chip select,
// decodes an op-code byte followed by operand bytes, and shifts a response byte
// out on CIPO during every operand byte slot.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        spi_select_in,
  input  logic        spi_clock_in,
  input  logic        spi_data_in,
  output logic        spi_data_out,
  output logic [7:0]  op_code_out,
  output logic        op_code_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic [31:0] operand_count_out,
  input  logic [7:0]  response_in,
  input  logic        response_valid_in
);

  typedef enum logic [1:0] {StIdle, StOpcode, StOperand} state_e;

  logic [SYNC_STAGES-1:0] sel_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   sel_prev_q;
  logic                   sclk_prev_q;

  logic sel_s;
  logic sclk_s;
  logic data_s;
  logic sel_fall;
  logic sclk_rise;
  logic sclk_fall;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_q;
  logic [7:0]  tx_q;
  logic [7:0]  op_code_q;
  logic        op_code_valid_q;
  logic [7:0]  operand_q;
  logic        operand_valid_q;
  logic [31:0] count_q;
  logic [7:0]  rx_byte;

  // Pin synchronizers plus one extra flop on select and clock for edge detection
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sel_sync_q  <= '0;
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      sel_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], spi_select_in};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clock_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data_in};
      sel_prev_q  <= sel_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sel_s     = sel_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign sel_fall  = ~sel_s & sel_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rx_byte   = {rx_q[6:0], data_s};

  // Transaction FSM with registered decode outputs and TX shifter
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q         <= StIdle;
      bit_cnt_q       <= 3'd0;
      rx_q            <= 8'h00;
      tx_q            <= 8'h00;
      op_code_q       <= 8'h00;
      op_code_valid_q <= 1'b0;
      operand_q       <= 8'h00;
      operand_valid_q <= 1'b0;
      count_q         <= 32'd0;
    end else if (sel_s) begin
      // Select high (which includes a detected rise) always aborts to idle;
      // a partial byte is dropped with no strobes.
      state_q         <= StIdle;
      bit_cnt_q       <= 3'd0;
      tx_q            <= 8'h00;
      op_code_valid_q <= 1'b0;
      operand_valid_q <= 1'b0;
      count_q         <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A select that was already low (e.g. across reset) gives no fall here
          if (sel_fall) begin
            state_q   <= StOpcode;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
          end
        end
        StOpcode: begin
          if (sclk_rise) begin
            rx_q      <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              op_code_q       <= rx_byte;
              op_code_valid_q <= 1'b1;
              state_q         <= StOperand;
            end
          end
        end
        StOperand: begin
          if (sclk_rise) begin
            rx_q      <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              operand_valid_q <= 1'b0;
            end
            if (bit_cnt_q == 3'd7) begin
              operand_q       <= rx_byte;
              operand_valid_q <= 1'b1;
              if (count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
              end
            end
          end else if (sclk_fall) begin
            // bit_cnt_q is 0 only on the fall that follows a byte's 8th rise
            if (bit_cnt_q == 3'd0) begin
              tx_q <= response_valid_in ? response_in : 8'h00;
            end else begin
              tx_q <= {tx_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_data_out      = tx_q[7];
  assign op_code_out       = op_code_q;
  assign op_code_valid_out = op_code_valid_q;
  assign operand_out       = operand_q;
  assign operand_valid_out = operand_valid_q;
  assign operand_count_out = count_q;

endmodule
